// File: rtl/frv_writeback.sv
// frv_writeback
//   Writeback stage in front of the GPR file. It arbitrates the execute result
//   channel and the LSU load-response channel onto the single GPR write port,
//   registers the winning write, forwards that in-flight write onto the three
//   GPR read ports, and tracks outstanding load destinations so that decode
//   can see read hazards.
//
// Ports
//   g_clk, g_reset                    clock, synchronous active-high reset
//   ex_valid/ex_ready/ex_rd/ex_wide/
//     ex_wdata/ex_wdata_hi            execute result channel (optionally 64-bit)
//   lsu_valid/lsu_ready/lsu_rd/
//     lsu_wdata                       load response channel (always 32-bit)
//   lsu_issue, lsu_issue_rd           load issued by decode (scoreboard set)
//   rd_wen/rd_wide/rd_addr/
//     rd_wdata/rd_wdata_hi            registered GPR write port
//   rsN_addr, rsN_gpr_data            GPR read address and raw read data
//   rsN_data                          forwarded operand
//   rsN_hazard                        operand waits on an outstanding load
module frv_writeback #(
    parameter bit FORWARD_EN   = 1'b1,
    parameter bit LSU_PRIORITY = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wide,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_wdata_hi,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_wdata,
    input  logic        lsu_issue,
    input  logic [4:0]  lsu_issue_rd,
    output logic        rd_wen,
    output logic        rd_wide,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_wdata,
    output logic [31:0] rd_wdata_hi,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rs3_addr,
    input  logic [31:0] rs1_gpr_data,
    input  logic [31:0] rs2_gpr_data,
    input  logic [31:0] rs3_gpr_data,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic [31:0] rs3_data,
    output logic        rs1_hazard,
    output logic        rs2_hazard,
    output logic        rs3_hazard
);

    typedef struct packed {
        logic [4:0]  rd;
        logic        wide;
        logic [31:0] wdata;
        logic [31:0] wdata_hi;
    } wb_req_t;

    localparam int NUM_RS = 3;

    wb_req_t ex_req, lsu_req, win;
    logic    collide, ex_xfer, lsu_xfer;
    logic [31:0] busy, busy_nxt;

    assign ex_req  = '{rd: ex_rd, wide: ex_wide, wdata: ex_wdata, wdata_hi: ex_wdata_hi};
    assign lsu_req = '{rd: lsu_rd, wide: 1'b0, wdata: lsu_wdata, wdata_hi: 32'd0};

    // Only a simultaneous request produces a loser; an idle channel stays
    // ready so a new request is accepted in the cycle it appears.
    assign collide   = ex_valid && lsu_valid;
    assign ex_ready  = !(collide && LSU_PRIORITY);
    assign lsu_ready = !(collide && !LSU_PRIORITY);
    assign ex_xfer   = ex_valid && ex_ready;
    assign lsu_xfer  = lsu_valid && lsu_ready;

    // At most one transfer per cycle, so the mux select is unambiguous.
    assign win = lsu_xfer ? lsu_req : ex_req;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rd_wen      <= 1'b0;
            rd_wide     <= 1'b0;
            rd_addr     <= 5'd0;
            rd_wdata    <= 32'd0;
            rd_wdata_hi <= 32'd0;
        end else if (ex_xfer || lsu_xfer) begin
            // A wide write to x0 still targets x1, hence the wide term.
            rd_wen      <= (win.rd != 5'd0) || win.wide;
            rd_wide     <= win.wide;
            rd_addr     <= win.wide ? {win.rd[4:1], 1'b0} : win.rd;
            rd_wdata    <= win.wdata;
            rd_wdata_hi <= win.wide ? win.wdata_hi : 32'd0;
        end else begin
            rd_wen  <= 1'b0;
            rd_wide <= 1'b0;
        end
    end

    // Scoreboard: clear on load completion, then set on issue so that a
    // same-cycle re-issue of the completing register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (lsu_xfer)
            busy_nxt[lsu_rd] = 1'b0;
        if (lsu_issue && lsu_issue_rd != 5'd0)
            busy_nxt[lsu_issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset)
            busy <= 32'd0;
        else
            busy <= busy_nxt;
    end

    // Per-operand forwarding and hazard lookup.
    logic [NUM_RS-1:0][4:0]  rs_addr;
    logic [NUM_RS-1:0][31:0] rs_gpr, rs_fwd;
    logic [NUM_RS-1:0]       rs_haz;

    assign rs_addr = {rs3_addr, rs2_addr, rs1_addr};
    assign rs_gpr  = {rs3_gpr_data, rs2_gpr_data, rs1_gpr_data};

    for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
        logic hit_lo, hit_hi;
        assign hit_lo = FORWARD_EN && rd_wen && rs_addr[i] != 5'd0 && rs_addr[i] == rd_addr;
        assign hit_hi = FORWARD_EN && rd_wen && rd_wide && rs_addr[i] == (rd_addr | 5'd1);
        assign rs_fwd[i] = (FORWARD_EN && rs_addr[i] == 5'd0) ? 32'd0       :
                           hit_lo                               ? rd_wdata    :
                           hit_hi                               ? rd_wdata_hi :
                                                                  rs_gpr[i];
        assign rs_haz[i] = busy[rs_addr[i]];
    end

    assign rs1_data   = rs_fwd[0];
    assign rs2_data   = rs_fwd[1];
    assign rs3_data   = rs_fwd[2];
    assign rs1_hazard = rs_haz[0];
    assign rs2_hazard = rs_haz[1];
    assign rs3_hazard = rs_haz[2];

endmodule

// File: tb/tb_frv_writeback.sv
module tb_frv_writeback;

    localparam logic [31:0] STALE = 32'hCAFE_0000;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        ex_valid, ex_ready, ex_wide;
    logic [4:0]  ex_rd;
    logic [31:0] ex_wdata, ex_wdata_hi;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_wdata;
    logic        lsu_issue;
    logic [4:0]  lsu_issue_rd;
    logic        rd_wen, rd_wide;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata, rd_wdata_hi;
    logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
    logic [31:0] rs1_gpr_data, rs2_gpr_data, rs3_gpr_data;
    logic [31:0] rs1_data, rs2_data, rs3_data;
    logic        rs1_hazard, rs2_hazard, rs3_hazard;

    int n_cmp = 0;
    int n_err = 0;

    always #5 g_clk = ~g_clk;

    frv_writeback #(.FORWARD_EN(1'b1), .LSU_PRIORITY(1'b1)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_wide(ex_wide),
        .ex_wdata(ex_wdata), .ex_wdata_hi(ex_wdata_hi),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
        .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd),
        .rd_wen(rd_wen), .rd_wide(rd_wide), .rd_addr(rd_addr),
        .rd_wdata(rd_wdata), .rd_wdata_hi(rd_wdata_hi),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs3_addr(rs3_addr),
        .rs1_gpr_data(rs1_gpr_data), .rs2_gpr_data(rs2_gpr_data), .rs3_gpr_data(rs3_gpr_data),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rs3_data(rs3_data),
        .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard), .rs3_hazard(rs3_hazard)
    );

    typedef struct {
        logic        ex_v;
        logic [4:0]  ex_rd;
        logic        ex_wide;
        logic [31:0] ex_wd;
        logic [31:0] ex_hi;
        logic        lsu_v;
        logic [4:0]  lsu_rd;
        logic [31:0] lsu_wd;
        logic [4:0]  rs1, rs2, rs3;
        logic        e_exr, e_lsr, e_wen, e_wide;
        logic [4:0]  e_addr;
        logic [31:0] e_wd, e_hi, e_rs1, e_rs2, e_rs3;
    } vec_t;

    vec_t vec [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_rd = 0; ex_wide = 0; ex_wdata = 0; ex_wdata_hi = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
        lsu_issue = 0; lsu_issue_rd = 0;
    endtask

    initial begin
        //        ex_v ex_rd wide ex_wd          ex_hi          lsu_v lsu_rd lsu_wd  rs1 rs2 rs3  exr lsr wen wide addr wd            hi      rs1d          rs2d   rs3d
        vec[0] = '{1, 5'd5,  0, 32'hDEADBEEF, 32'h0,         0, 5'd0, 32'h0,  5'd5,  5'd6,  5'd0,  1, 1, 1, 0, 5'd5,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, STALE, 32'h0};
        vec[1] = '{1, 5'd10, 1, 32'hA,        32'hB,         0, 5'd0, 32'h0,  5'd10, 5'd11, 5'd10, 1, 1, 1, 1, 5'd10, 32'hA,        32'hB, 32'hA,        32'hB, 32'hA};
        vec[2] = '{1, 5'd0,  0, 32'hFF,       32'h0,         0, 5'd0, 32'h0,  5'd0,  5'd5,  5'd1,  1, 1, 0, 0, 5'd0,  32'hFF,       32'h0, 32'h0,        STALE, STALE};
        vec[3] = '{1, 5'd0,  1, 32'h1,        32'h2,         0, 5'd0, 32'h0,  5'd1,  5'd0,  5'd2,  1, 1, 1, 1, 5'd0,  32'h1,        32'h2, 32'h2,        32'h0, STALE};
        vec[4] = '{0, 5'd0,  0, 32'h0,        32'h0,         1, 5'd9, 32'h99, 5'd9,  5'd8,  5'd9,  1, 1, 1, 0, 5'd9,  32'h99,       32'h0, 32'h99,       STALE, 32'h99};
        vec[5] = '{1, 5'd3,  0, 32'h33,       32'h77,        0, 5'd0, 32'h0,  5'd3,  5'd2,  5'd3,  1, 1, 1, 0, 5'd3,  32'h33,       32'h0, 32'h33,       STALE, 32'h33};
        vec[6] = '{0, 5'd0,  0, 32'h0,        32'h0,         0, 5'd0, 32'h0,  5'd3,  5'd0,  5'd4,  1, 1, 0, 0, 5'd3,  32'h33,       32'h0, STALE,        32'h0, STALE};
        vec[7] = '{1, 5'd31, 0, 32'h1234_5678, 32'h0,        0, 5'd0, 32'h0,  5'd31, 5'd30, 5'd31, 1, 1, 1, 0, 5'd31, 32'h12345678, 32'h0, 32'h12345678, STALE, 32'h12345678};

        rs1_gpr_data = STALE; rs2_gpr_data = STALE; rs3_gpr_data = STALE;
        rs1_addr = 0; rs2_addr = 0; rs3_addr = 0;
        idle_inputs();

        // Reset state
        g_reset = 1;
        tick(); tick();
        g_reset = 0;
        rs1_addr = 5'd7;
        #1;
        chk("reset rd_wen", 32'(rd_wen), 32'd0);
        chk("reset rd_wide", 32'(rd_wide), 32'd0);
        chk("reset rd_addr", 32'(rd_addr), 32'd0);
        chk("reset rd_wdata", rd_wdata, 32'd0);
        chk("reset rd_wdata_hi", rd_wdata_hi, 32'd0);
        chk("reset ex_ready", 32'(ex_ready), 32'd1);
        chk("reset lsu_ready", 32'(lsu_ready), 32'd1);
        chk("reset hazard", 32'(rs1_hazard), 32'd0);

        // Table-driven single transfers
        for (int i = 0; i < 8; i++) begin
            ex_valid = vec[i].ex_v; ex_rd = vec[i].ex_rd; ex_wide = vec[i].ex_wide;
            ex_wdata = vec[i].ex_wd; ex_wdata_hi = vec[i].ex_hi;
            lsu_valid = vec[i].lsu_v; lsu_rd = vec[i].lsu_rd; lsu_wdata = vec[i].lsu_wd;
            #1;
            chk($sformatf("v%0d ex_ready", i), 32'(ex_ready), 32'(vec[i].e_exr));
            chk($sformatf("v%0d lsu_ready", i), 32'(lsu_ready), 32'(vec[i].e_lsr));
            tick();
            idle_inputs();
            rs1_addr = vec[i].rs1; rs2_addr = vec[i].rs2; rs3_addr = vec[i].rs3;
            #1;
            chk($sformatf("v%0d rd_wen", i), 32'(rd_wen), 32'(vec[i].e_wen));
            chk($sformatf("v%0d rd_wide", i), 32'(rd_wide), 32'(vec[i].e_wide));
            chk($sformatf("v%0d rd_addr", i), 32'(rd_addr), 32'(vec[i].e_addr));
            chk($sformatf("v%0d rd_wdata", i), rd_wdata, vec[i].e_wd);
            chk($sformatf("v%0d rd_wdata_hi", i), rd_wdata_hi, vec[i].e_hi);
            chk($sformatf("v%0d rs1_data", i), rs1_data, vec[i].e_rs1);
            chk($sformatf("v%0d rs2_data", i), rs2_data, vec[i].e_rs2);
            chk($sformatf("v%0d rs3_data", i), rs3_data, vec[i].e_rs3);
        end

        // Collision: LSU wins, execute holds and goes next cycle
        ex_valid = 1; ex_rd = 5'd8; ex_wdata = 32'h22;
        lsu_valid = 1; lsu_rd = 5'd7; lsu_wdata = 32'h11;
        #1;
        chk("coll c0 lsu_ready", 32'(lsu_ready), 32'd1);
        chk("coll c0 ex_ready", 32'(ex_ready), 32'd0);
        tick();
        lsu_valid = 0;
        #1;
        chk("coll c1 rd_wen", 32'(rd_wen), 32'd1);
        chk("coll c1 rd_addr", 32'(rd_addr), 32'd7);
        chk("coll c1 rd_wdata", rd_wdata, 32'h11);
        chk("coll c1 ex_ready", 32'(ex_ready), 32'd1);
        tick();
        idle_inputs();
        #1;
        chk("coll c2 rd_wen", 32'(rd_wen), 32'd1);
        chk("coll c2 rd_addr", 32'(rd_addr), 32'd8);
        chk("coll c2 rd_wdata", rd_wdata, 32'h22);

        // Scoreboard: issue, hazard, completion with forwarding
        rs1_addr = 5'd12; rs2_addr = 5'd0; rs3_addr = 5'd13;
        lsu_issue = 1; lsu_issue_rd = 5'd12;
        #1;
        chk("sb pre-issue hazard", 32'(rs1_hazard), 32'd0);
        tick();
        lsu_issue = 0;
        #1;
        chk("sb busy hazard", 32'(rs1_hazard), 32'd1);
        chk("sb other hazard", 32'(rs3_hazard), 32'd0);
        lsu_valid = 1; lsu_rd = 5'd12; lsu_wdata = 32'hC0DE;
        #1;
        chk("sb accept lsu_ready", 32'(lsu_ready), 32'd1);
        chk("sb accept hazard", 32'(rs1_hazard), 32'd1);
        tick();
        lsu_valid = 0;
        #1;
        chk("sb done hazard", 32'(rs1_hazard), 32'd0);
        chk("sb done fwd", rs1_data, 32'hC0DE);

        // Same-cycle issue and completion of x12: set wins
        lsu_issue = 1; lsu_issue_rd = 5'd12;
        lsu_valid = 1; lsu_rd = 5'd12; lsu_wdata = 32'h1;
        tick();
        idle_inputs();
        #1;
        chk("sb set-wins hazard", 32'(rs1_hazard), 32'd1);
        lsu_valid = 1; lsu_rd = 5'd12; lsu_wdata = 32'h2;
        tick();
        idle_inputs();
        #1;
        chk("sb final clear", 32'(rs1_hazard), 32'd0);

        // x0 is never marked busy
        lsu_issue = 1; lsu_issue_rd = 5'd0;
        tick();
        idle_inputs();
        #1;
        chk("sb x0 hazard", 32'(rs2_hazard), 32'd0);

        // Reset mid-operation
        lsu_issue = 1; lsu_issue_rd = 5'd3;
        tick();
        idle_inputs();
        rs1_addr = 5'd3;
        #1;
        chk("rst busy3 set", 32'(rs1_hazard), 32'd1);
        ex_valid = 1; ex_rd = 5'd4; ex_wdata = 32'h44; ex_wide = 1; ex_wdata_hi = 32'h45;
        g_reset = 1;
        tick();
        g_reset = 0;
        idle_inputs();
        #1;
        chk("rst busy3 clear", 32'(rs1_hazard), 32'd0);
        chk("rst rd_wen", 32'(rd_wen), 32'd0);
        chk("rst rd_wide", 32'(rd_wide), 32'd0);
        chk("rst rd_addr", 32'(rd_addr), 32'd0);
        chk("rst rd_wdata", rd_wdata, 32'd0);
        chk("rst rd_wdata_hi", rd_wdata_hi, 32'd0);
        tick();
        chk("rst no late write", 32'(rd_wen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
